mcu51_cycle_sequencer: RTL
==========================

// Module: mcu51_cycle_sequencer
// PURPOSE
//  Machine-cycle timing controller for the MCU51 core.
//  Divides each machine cycle (MC) into 6 states S1..S6 x 2 phases P1/P2, i.e. 12 clk ticks.
//  Sequences opcode/operand fetch on the shared BUS: ALE, PSEN, CODE_CS, IR_en, PC_en, operand latch.
//  Sits between the clock input and the control unit. The control unit supplies instruction length
//  and operand-fetch requests; this block tells the control unit when an instruction ends.
// PARAMETERS
//  TICKS_PER_MC  12  clk ticks per machine cycle (2 per state); fixed, checked at elaboration
//  MC_W          2   width of MC index; supports 1..4 MCs per instruction (MUL/DIV = 4)
// PORTS
//  clk        in   1     core clock (XTAL1)
//  reset      in   1     synchronous, active-low reset
//  EA         in   1     1 = internal ROM, 0 = external ROM (enables PSEN strobes)
//  hold       in   1     1 = freeze sequencer this cycle (debug/wait)
//  n_mc       in   MC_W  MC count minus 1 for current opcode; valid from tick 4 of MC0
//  fetch2_req in   1     fetch next code byte in this MC; sampled at tick 6
//  state      out  3     current state, 1..6 (S1..S6)
//  Phase      out  1     0 = P1, 1 = P2
//  mc_idx     out  MC_W  index of current MC within instruction
//  ALE        out  1     address latch enable
//  PSEN       out  1     program store enable, active low
//  CODE_CS    out  1     code ROM chip select
//  IR_en      out  1     load IR from BUS
//  PC_en      out  1     advance PC by one
//  byte_en    out  1     latch operand byte (direct/rel/bit/data) from BUS
//  instr_end  out  1     one-tick pulse on last tick of last MC
// BEHAVIOUR
//  - tick = 2*(state-1) + Phase, range 0..11.
//  - All outputs registered: a strobe "at tick t" is high exactly during the cycle in which tick == t.
//  - Reset (reset == 0 at posedge):
//      tick = 0, mc_idx = 0, state = 1, Phase = 0.
//      ALE = 0, PSEN = 1, CODE_CS = IR_en = PC_en = byte_en = instr_end = 0.
//      Latched n_mc = 0, latched fetch2 = 0.
//    Reset mid-instruction abandons it; the first cycle after release is tick 0 of MC0.
//  - Counter: tick increments each non-hold cycle and wraps 11 -> 0.
//    On wrap: mc_idx increments if mc_idx < n_mc_lat, else mc_idx -> 0 (new instruction).
//  - n_mc_lat captured at tick 4 of MC0 only. Before that, n_mc_lat = 0.
//    n_mc changes outside tick 4 of MC0 are ignored.
//  - fetch2_lat captured at tick 6 of every MC and cleared at tick 0.
//  - ALE = 1 at ticks 1,2,7,8 of every MC. Not suppressed for internal fetch.
//  - Opcode fetch, MC0 only:
//      CODE_CS = 1 at ticks 2,3.
//      IR_en = 1 at tick 3.
//      PC_en = 1 at tick 4.
//  - Operand fetch, any MC with fetch2_lat = 1:
//      CODE_CS = 1 at ticks 8,9.
//      byte_en = 1 at tick 9.
//      PC_en = 1 at tick 10.
//  - PSEN = 0 at ticks 3..5 (MC0) and ticks 9..11 (when fetch2_lat), only while EA == 0.
//    Otherwise PSEN = 1. EA is sampled each cycle.
//  - instr_end = 1 at tick 11 when mc_idx == n_mc_lat.
//  - hold == 1:
//      tick, mc_idx and latches are frozen.
//      ALE, CODE_CS, IR_en, PC_en, byte_en and instr_end are forced to 0; PSEN is forced to 1.
//      state and Phase keep showing the frozen tick.
//    On release, the frozen tick's strobes reassert for one cycle, then counting resumes.
//    A pulse interrupted by hold is therefore issued exactly once.
//  - Simultaneous events:
//      reset has priority over hold.
//      hold at tick 4 of MC0 delays n_mc capture to the release cycle.
//      hold at tick 6 delays fetch2_req sampling the same way.
// STRUCTURE
//  - Shared include mcu51_timing.vh holds localparams:
//      TICK_ALE_*, TICK_IR, TICK_PC_OP, TICK_OPND, TICK_PC_B2, TICK_LAST = 11.
//      State encodings S1..S6.
//    The control unit uses the same file.
//  - One sub-module, mcu51_tick_decode: combinational map from (next_tick, mc0, fetch2_lat, EA, hold)
//    to next strobe values, registered in the parent.
//  - Parent holds the tick counter, MC counter, n_mc/fetch2 latches and output registers.
// TESTING
//  1. reset = 0 for 3 clk, then 1 -> cycle 0: tick 0, state = 1, Phase = 0, PSEN = 1, ALE = 0;
//     ALE high at ticks 1,2,7,8.
//  2. EA = 1, n_mc = 0, fetch2_req = 0 -> IR_en at tick 3, PC_en at tick 4 only, PSEN stays 1,
//     instr_end at tick 11, mc_idx stays 0.
//  3. EA = 0, n_mc = 1, fetch2_req = 1 in MC0 only -> PSEN low at ticks 3-5 and 9-11 of MC0, none in MC1;
//     byte_en at MC0 tick 9; instr_end at MC1 tick 11.
//  4. n_mc = 3 (MUL) -> mc_idx 0,1,2,3,0; exactly one instr_end per 48 clk; 2nd IR_en 48 clk after the 1st.
//  5. hold = 1 for 5 clk starting at MC0 tick 3 -> IR_en low during hold, one IR_en on release cycle,
//     PC_en the next cycle; total instruction length 17 clk.
//  6. reset = 0 at MC1 tick 6 of 2-MC instruction -> next cycle all outputs at reset values;
//     no instr_end from abandoned instruction.

Source files
------------

// File: rtl/mcu51_cycle_sequencer_pkg.sv
// Shared machine-cycle timing constants for the MCU51 sequencer and control unit.
// Tick numbering: tick = 2*(state-1) + phase, 0..11 within one machine cycle.
package mcu51_cycle_sequencer_pkg;

  localparam int TICKS_PER_MC_FIXED = 12;
  localparam int TICK_W             = 4;

  // Address latch strobes, twice per machine cycle
  localparam logic [3:0] TICK_ALE_A0 = 4'd1;
  localparam logic [3:0] TICK_ALE_A1 = 4'd2;
  localparam logic [3:0] TICK_ALE_B0 = 4'd7;
  localparam logic [3:0] TICK_ALE_B1 = 4'd8;
  localparam logic [3:0][3:0] TICK_ALE_ALL = {TICK_ALE_A0, TICK_ALE_A1, TICK_ALE_B0, TICK_ALE_B1};

  // Opcode fetch window (MC0 only)
  localparam logic [3:0] TICK_CS_OP       = 4'd2;
  localparam logic [3:0] TICK_IR          = 4'd3;
  localparam logic [3:0] TICK_PC_OP       = 4'd4;
  localparam logic [3:0] TICK_PSEN_OP_END = 4'd5;

  // Latch sample points
  localparam logic [3:0] TICK_NMC = 4'd4;
  localparam logic [3:0] TICK_F2  = 4'd6;

  // Operand fetch window (any MC with a second-byte request)
  localparam logic [3:0] TICK_CS_B2 = 4'd8;
  localparam logic [3:0] TICK_OPND  = 4'd9;
  localparam logic [3:0] TICK_PC_B2 = 4'd10;
  localparam logic [3:0] TICK_LAST  = 4'd11;

  typedef enum logic [2:0] {
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_e;

  // Bus strobes produced for one tick
  typedef struct packed {
    logic ale;
    logic psen;
    logic code_cs;
    logic ir_en;
    logic pc_en;
    logic byte_en;
  } strobe_t;

  // Two ticks per state: S1 covers ticks 0/1, S6 covers ticks 10/11
  function automatic state_e tick_to_state(input logic [3:0] t);
    return state_e'(t[3:1] + 3'd1);
  endfunction

endpackage

// File: rtl/mcu51_tick_decode.sv
// Combinational strobe map for the tick about to be displayed.
// The parent registers these values so each strobe is high exactly during its tick.
module mcu51_tick_decode
  import mcu51_cycle_sequencer_pkg::*;
(
  input  logic [3:0] next_tick,
  input  logic       mc0,
  input  logic       fetch2_lat,
  input  logic       ea,
  input  logic       hold,
  output strobe_t    strobes
);

  logic [3:0] ale_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ale
    assign ale_hit[gi] = (next_tick == TICK_ALE_ALL[gi]);
  end

  // Decode bus strobes; a held cycle drives every strobe inactive
  always_comb begin
    strobes      = '0;
    strobes.psen = 1'b1;
    if (!hold) begin
      strobes.ale     = |ale_hit;
      strobes.code_cs = (mc0 && (next_tick == TICK_CS_OP || next_tick == TICK_IR)) ||
                        (fetch2_lat && (next_tick == TICK_CS_B2 || next_tick == TICK_OPND));
      strobes.ir_en   = mc0 && (next_tick == TICK_IR);
      strobes.pc_en   = (mc0 && (next_tick == TICK_PC_OP)) ||
                        (fetch2_lat && (next_tick == TICK_PC_B2));
      strobes.byte_en = fetch2_lat && (next_tick == TICK_OPND);
      // PSEN only strobes for external code; internal ROM fetches keep it idle
      strobes.psen    = ea ||
                        !((mc0 && (next_tick >= TICK_IR) && (next_tick <= TICK_PSEN_OP_END)) ||
                          (fetch2_lat && (next_tick >= TICK_OPND) && (next_tick <= TICK_LAST)));
    end
  end

endmodule

// File: rtl/mcu51_cycle_sequencer.sv
// Machine-cycle sequencer: 12 ticks per MC, 1..4 MCs per instruction.
// Holds the tick/MC counters, instruction-length and second-byte latches and the
// registered bus strobes. A held cycle shows the tick it interrupted with strobes
// idle; the release cycle re-issues that tick's strobes before counting resumes.
module mcu51_cycle_sequencer
  import mcu51_cycle_sequencer_pkg::*;
#(
  parameter int TICKS_PER_MC = 12,
  parameter int MC_W         = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EA,
  input  logic            hold,
  input  logic [MC_W-1:0] n_mc,
  input  logic            fetch2_req,
  output logic [2:0]      state,
  output logic            Phase,
  output logic [MC_W-1:0] mc_idx,
  output logic            ALE,
  output logic            PSEN,
  output logic            CODE_CS,
  output logic            IR_en,
  output logic            PC_en,
  output logic            byte_en,
  output logic            instr_end
);

  if (TICKS_PER_MC != TICKS_PER_MC_FIXED) begin : g_bad_ticks
    $error("mcu51_cycle_sequencer: TICKS_PER_MC must be 12");
  end

  logic [3:0]      tick_reg, tick_next;
  logic [MC_W-1:0] mc_reg, mc_next;
  logic [MC_W-1:0] n_mc_reg, n_mc_next;
  logic            fetch2_reg, fetch2_next;
  logic            stall_reg;
  state_e          state_reg;
  logic            phase_reg;
  strobe_t         strobe_reg, strobe_next;
  logic            instr_end_reg, instr_end_next;

  // Advance counters and latches; a cycle that followed a hold repeats its tick
  always_comb begin
    tick_next   = tick_reg;
    mc_next     = mc_reg;
    n_mc_next   = n_mc_reg;
    fetch2_next = fetch2_reg;
    if (!stall_reg) begin
      if (tick_reg == TICK_NMC && mc_reg == '0) begin
        n_mc_next = n_mc;
      end
      if (tick_reg == TICK_F2) begin
        fetch2_next = fetch2_req;
      end
      if (tick_reg == TICK_LAST) begin
        tick_next   = '0;
        fetch2_next = 1'b0;
        if (mc_reg < n_mc_next) begin
          mc_next = mc_reg + MC_W'(1);
        end else begin
          // Last MC done: next instruction starts with length unknown
          mc_next   = '0;
          n_mc_next = '0;
        end
      end else begin
        tick_next = tick_reg + 4'd1;
      end
    end
  end

  mcu51_tick_decode u_tick_decode (
    .next_tick  (tick_next),
    .mc0        (mc_next == '0),
    .fetch2_lat (fetch2_next),
    .ea         (EA),
    .hold       (hold),
    .strobes    (strobe_next)
  );

  assign instr_end_next = !hold && (tick_next == TICK_LAST) && (mc_next == n_mc_next);

  // Register counters, latches and every output; reset wins over hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_reg      <= '0;
      mc_reg        <= '0;
      n_mc_reg      <= '0;
      fetch2_reg    <= 1'b0;
      stall_reg     <= 1'b0;
      state_reg     <= S1;
      phase_reg     <= 1'b0;
      strobe_reg    <= '{ale: 1'b0, psen: 1'b1, code_cs: 1'b0, ir_en: 1'b0,
                         pc_en: 1'b0, byte_en: 1'b0};
      instr_end_reg <= 1'b0;
    end else begin
      tick_reg      <= tick_next;
      mc_reg        <= mc_next;
      n_mc_reg      <= n_mc_next;
      fetch2_reg    <= fetch2_next;
      stall_reg     <= hold;
      state_reg     <= tick_to_state(tick_next);
      phase_reg     <= tick_next[0];
      strobe_reg    <= strobe_next;
      instr_end_reg <= instr_end_next;
    end
  end

  assign state     = state_reg;
  assign Phase     = phase_reg;
  assign mc_idx    = mc_reg;
  assign ALE       = strobe_reg.ale;
  assign PSEN      = strobe_reg.psen;
  assign CODE_CS   = strobe_reg.code_cs;
  assign IR_en     = strobe_reg.ir_en;
  assign PC_en     = strobe_reg.pc_en;
  assign byte_en   = strobe_reg.byte_en;
  assign instr_end = instr_end_reg;

endmodule
